race_ctrl: RTL
==============

Name: race_ctrl

Overview:
- Per-frame race sequencer and motion controller for one player's car sprite.
- Runs the start countdown and the race, finish and foul states. Integrates throttle and gear into velocity and position once per frame.
- Drives the car_xpos/car_ypos inputs of the car sprite drawer. Indicator outputs go to the HUD overlay.
- One instance per player. All state advances only on the frame tick derived from vsync.

Parameters:
- START_X, 0, reset/idle horizontal position (pixels).
- START_Y, 300, vertical lane position (pixels, constant).
- FINISH_X, 511, xpos at which the race ends. Car is 512 wide on a 1024 screen.
- COUNT_FRAMES, 60, frames per countdown light.
- DRAG, 1, velocity decay per frame when throttle released (1/16 px/frame units).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- vsync_in  in  1  timing-chain vsync; rising edge = frame boundary
- start_btn  in  1  debounced level; rising edge used
- throttle  in  1  level, sampled at tick
- shift_up  in  1  one-cycle pulse
- shift_down  in  1  one-cycle pulse
- car_xpos  out  12  sprite x (integer pixels)
- car_ypos  out  12  sprite y
- velocity  out  10  speed, 1/16 px per frame
- gear  out  3  1..4
- lights  out  3  countdown ambers lit, thermometer code
- go  out  1  high in RACE
- finished  out  1  high in FINISH
- foul  out  1  high in FOUL
- race_time  out  16  frames spent in RACE, saturating

Behaviour:
- Reset values:
  - car_xpos=START_X, car_ypos=START_Y, velocity=0, gear=1, lights=0, go=0, finished=0, foul=0, race_time=0.
  - State IDLE, pending shifts cleared.
- Tick:
  - vsync_in registered once. tick=1 for exactly one clk on the cycle after a 0->1 transition is seen.
  - All state, velocity and position updates occur only on tick cycles. Outputs are registered and change the cycle after tick.
- Position accumulator: pos[15:0] with 4 fractional bits; car_xpos={0,pos[15:4]}. car_ypos is always START_Y.
- Start edge: start_btn edge detected on clk, latched as pending and consumed at the next tick.
- Shifts:
  - shift_up/shift_down latched as pending flags, applied at the next tick, then cleared.
  - Both pending together: both discarded.
  - Gear saturates at 1 and 4. Shifts are accepted in every state.
- IDLE:
  - Hold pos=START_X<<4, velocity=0, race_time=0, lights=0.
  - Pending start -> COUNTDOWN, frame counter=0.
- COUNTDOWN:
  - Frame counter increments per tick.
  - lights=001 after COUNT_FRAMES ticks, 011 after 2*COUNT_FRAMES, 111 after 3*COUNT_FRAMES.
  - At 3*COUNT_FRAMES: -> RACE, go=1, lights=0.
  - throttle=1 at any COUNTDOWN tick -> FOUL. The foul check has priority over light advance on the same tick.
- RACE, per tick:
  - pos += velocity, using the pre-update velocity (one-tick lag).
  - Then velocity: if velocity>VMAX[gear], clamp to VMAX[gear] (downshift braking).
  - Else if throttle, velocity=min(velocity+ACCEL[gear], VMAX[gear]).
  - Else velocity=max(velocity-DRAG, 0).
  - race_time += 1, saturating at 16'hFFFF.
  - If new pos[15:4] >= FINISH_X: pos=FINISH_X<<4, velocity=0, -> FINISH.
- FINISH and FOUL:
  - Hold position, velocity and race_time. finished or foul asserted respectively.
  - Pending start -> IDLE. Start is ignored in COUNTDOWN and RACE (pending cleared).
- Arithmetic:
  - Sums computed 1 bit wider than the operands, then clamped. There is no wrap-around.
- Reset mid-race forces all reset values on the next clk regardless of state or pending flags.

Decomposition:
- Package race_pkg:
  - State enum (IDLE, COUNTDOWN, RACE, FINISH, FOUL).
  - Width constants: VEL_W=10, POS_W=16, FRAC=4.
  - Gear tables: VMAX={160,320,560,880}, ACCEL={12,8,5,3}, indexed by gear-1.
- Sub-module rise_edge: register plus AND-NOT, one-cycle pulse.
  - Instantiated for vsync_in and start_btn.

Test Plan (COUNT_FRAMES=2, START_X=0, FINISH_X=511):
- Countdown: start pulse, throttle=0, 6 ticks -> lights 001@tick2, 011@tick4, then go=1 and lights=000@tick6. race_time=0 on entry.
- Gear-1 launch: throttle held in RACE for 4 ticks -> velocity 12,24,36,48; pos=72, car_xpos=4. After 14 ticks velocity=160 and holds.
- False start: throttle=1 at first COUNTDOWN tick -> FOUL, foul=1, car_xpos=0. Start pulse -> IDLE, foul=0.
- Downshift clamp: gear 3, velocity=500, shift_down at tick -> gear=2, velocity=320 next tick. Simultaneous up+down pulses -> gear unchanged.
- Finish: run until pos crosses 511<<4 -> car_xpos=511, velocity=0, finished=1. race_time frozen; further ticks change nothing.
- Reset mid-RACE (velocity=300, car_xpos=200) -> next clk: car_xpos=0, velocity=0, gear=1, IDLE, all flags 0.

Source files
------------

// File: rtl/race_pkg.sv
// Shared types, widths and gear tables for the per-player race controller.
package race_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_RACE,
    S_FINISH,
    S_FOUL
  } state_e;

  localparam int VEL_W  = 10;
  localparam int POS_W  = 16;
  localparam int FRAC   = 4;
  localparam int GEAR_W = 3;
  localparam int XPIX_W = POS_W - FRAC;

  localparam logic [GEAR_W-1:0] GEAR_MIN = 3'd1;
  localparam logic [GEAR_W-1:0] GEAR_MAX = 3'd4;

  // Indexed by gear-1; element 0 is the rightmost entry.
  localparam logic [3:0][VEL_W-1:0] VMAX  = {10'd880, 10'd560, 10'd320, 10'd160};
  localparam logic [3:0][VEL_W-1:0] ACCEL = {10'd3, 10'd5, 10'd8, 10'd12};

  function automatic logic [1:0] gear_idx(input logic [GEAR_W-1:0] gear);
    return 2'(gear - GEAR_MIN);
  endfunction

endpackage

// File: rtl/rise_edge.sv
// One-cycle pulse on the clock after a 0->1 transition of sig_i is seen.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  // NOTE: clocked state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/race_ctrl.sv
// Frame-tick race sequencer and car motion integrator for one player.
module race_ctrl
  import race_pkg::*;
#(
  parameter int unsigned START_X      = 0,
  parameter int unsigned START_Y      = 300,
  parameter int unsigned FINISH_X     = 511,
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned DRAG         = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync_in,
  input  logic        start_btn,
  input  logic        throttle,
  input  logic        shift_up,
  input  logic        shift_down,
  output logic [11:0] car_xpos,
  output logic [11:0] car_ypos,
  output logic [9:0]  velocity,
  output logic [2:0]  gear,
  output logic [2:0]  lights,
  output logic        go,
  output logic        finished,
  output logic        foul,
  output logic [15:0] race_time
);

  localparam int CNT_W = $clog2(3 * COUNT_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_L1    = CNT_W'(COUNT_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_L2    = CNT_W'(2 * COUNT_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_GO    = CNT_W'(3 * COUNT_FRAMES);
  localparam logic [POS_W-1:0]  START_POS = POS_W'(START_X << FRAC);
  localparam logic [POS_W-1:0]  FINISH_POS = POS_W'(FINISH_X << FRAC);
  localparam logic [XPIX_W-1:0] FINISH_PX = XPIX_W'(FINISH_X);
  localparam logic [VEL_W-1:0]  DRAG_V    = VEL_W'(DRAG);

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [VEL_W-1:0]    vel_q, vel_d;
  logic [GEAR_W-1:0]   gear_q, gear_d;
  logic [2:0]          lights_q, lights_d;
  logic [15:0]         rt_q, rt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_pend_q, start_pend_d;
  logic                up_pend_q, up_pend_d;
  logic                dn_pend_q, dn_pend_d;

  logic                vsync_q;
  logic                tick;
  logic                start_rise;

  always_ff @(posedge clk) begin
    if (reset) vsync_q <= 1'b0;
    else       vsync_q <= vsync_in;
  end

  rise_edge u_vsync_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (vsync_q),
    .pulse_o(tick)
  );

  rise_edge u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (start_btn),
    .pulse_o(start_rise)
  );

  // Requests arriving on the tick cycle itself are served by that tick.
  logic start_now, up_now, dn_now;
  assign start_now = start_pend_q | start_rise;
  assign up_now    = up_pend_q | shift_up;
  assign dn_now    = dn_pend_q | shift_down;

  logic [GEAR_W-1:0] gear_next;
  always_comb begin
    gear_next = gear_q;
    if (up_now && !dn_now && gear_q != GEAR_MAX)      gear_next = gear_q + 3'd1;
    else if (dn_now && !up_now && gear_q != GEAR_MIN) gear_next = gear_q - 3'd1;
  end

  // Motion uses the gear that results from this tick's shift.
  logic [VEL_W-1:0] vmax, accel;
  assign vmax  = VMAX[gear_idx(gear_next)];
  assign accel = ACCEL[gear_idx(gear_next)];

  logic [POS_W:0]   pos_sum;
  logic [POS_W-1:0] pos_new;
  logic [VEL_W:0]   vel_sum;
  logic [VEL_W-1:0] vel_new;
  logic [15:0]      rt_sat;
  logic [CNT_W-1:0] cnt_inc;

  assign pos_sum = {1'b0, pos_q} + (POS_W + 1)'(vel_q);
  assign pos_new = pos_sum[POS_W] ? {POS_W{1'b1}} : pos_sum[POS_W-1:0];
  assign vel_sum = {1'b0, vel_q} + {1'b0, accel};
  assign rt_sat  = (rt_q == 16'hFFFF) ? rt_q : rt_q + 16'd1;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    vel_new = vel_q;
    if (vel_q > vmax)                vel_new = vmax;
    else if (throttle)               vel_new = (vel_sum > {1'b0, vmax}) ? vmax : vel_sum[VEL_W-1:0];
    else if (vel_q >= DRAG_V)        vel_new = vel_q - DRAG_V;
    else                             vel_new = '0;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    vel_d        = vel_q;
    gear_d       = gear_q;
    lights_d     = lights_q;
    rt_d         = rt_q;
    cnt_d        = cnt_q;
    start_pend_d = start_now;
    up_pend_d    = up_now;
    dn_pend_d    = dn_now;

    if (tick) begin
      start_pend_d = 1'b0;
      up_pend_d    = 1'b0;
      dn_pend_d    = 1'b0;
      gear_d       = gear_next;

      case (state_q)
        S_IDLE: begin
          pos_d    = START_POS;
          vel_d    = '0;
          rt_d     = '0;
          lights_d = '0;
          if (start_now) begin
            state_d = S_COUNTDOWN;
            cnt_d   = '0;
          end
        end

        S_COUNTDOWN: begin
          if (throttle) begin
            state_d  = S_FOUL;
            lights_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_GO) begin
              state_d  = S_RACE;
              lights_d = '0;
            end else if (cnt_inc == CNT_L2) begin
              lights_d = 3'b011;
            end else if (cnt_inc == CNT_L1) begin
              lights_d = 3'b001;
            end
          end
        end

        S_RACE: begin
          rt_d = rt_sat;
          if (pos_new[POS_W-1:FRAC] >= FINISH_PX) begin
            pos_d   = FINISH_POS;
            vel_d   = '0;
            state_d = S_FINISH;
          end else begin
            pos_d = pos_new;
            vel_d = vel_new;
          end
        end

        S_FINISH, S_FOUL: begin
          if (start_now) begin
            state_d  = S_IDLE;
            pos_d    = START_POS;
            vel_d    = '0;
            rt_d     = '0;
            lights_d = '0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pos_q        <= START_POS;
      vel_q        <= '0;
      gear_q       <= GEAR_MIN;
      lights_q     <= '0;
      rt_q         <= '0;
      cnt_q        <= '0;
      start_pend_q <= 1'b0;
      up_pend_q    <= 1'b0;
      dn_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      vel_q        <= vel_d;
      gear_q       <= gear_d;
      lights_q     <= lights_d;
      rt_q         <= rt_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      up_pend_q    <= up_pend_d;
      dn_pend_q    <= dn_pend_d;
    end
  end

  assign car_xpos  = pos_q[POS_W-1:FRAC];
  assign car_ypos  = 12'(START_Y);
  assign velocity  = vel_q;
  assign gear      = gear_q;
  assign lights    = lights_q;
  assign go        = (state_q == S_RACE);
  assign finished  = (state_q == S_FINISH);
  assign foul      = (state_q == S_FOUL);
  assign race_time = rt_q;

endmodule
